// File: rtl/aes128_cipher_core.sv
// aes128_cipher_core
//   Iterative AES-128 block cipher, one round per clock. DECRYPT selects the forward cipher (0)
//   or the inverse cipher (1). A block and key are captured on the first edge that sees
//   inputsLoadedFlag high in IDLE; the result is registered onto outputData and dataDoneFlag
//   rises at completion and holds until the flag falls or resetModule is asserted.
//   Encryption: 10 clocks after the load edge. Decryption: 10 key-expansion clocks, then
//   10 inverse rounds (20 clocks total).
// Ports
//   clock            in   1    rising-edge clock
//   resetModule      in   1    synchronous reset, active-high; clears everything
//   inputData        in   128  plaintext / ciphertext, [127:120] is byte 0
//   key              in   128  cipher key, [127:120] is key byte 0
//   inputsLoadedFlag in   1    level request, sampled only in IDLE and DONE
//   outputData       out  128  registered result, updated only at completion or reset
//   dataDoneFlag     out  1    high while outputData holds a finished result
module aes128_cipher_core #(
  parameter int unsigned DECRYPT = 0
) (
  input  logic         clock,
  input  logic         resetModule,
  input  logic [127:0] inputData,
  input  logic [127:0] key,
  input  logic         inputsLoadedFlag,
  output logic [127:0] outputData,
  output logic         dataDoneFlag
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StKeyExp = 2'd1;
  localparam logic [1:0] StRound  = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

  // ---------------------------------------------------------------------------------------------
  // GF(2^8) arithmetic, polynomial 0x11b
  // ---------------------------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 == a^-1 for a != 0, and maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return gf_inv({b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05);
  endfunction

  // ---------------------------------------------------------------------------------------------
  // Block transforms; byte i of the state lives at [127-8i -: 8], column c is word c.
  // ---------------------------------------------------------------------------------------------
  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  // Row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*((c+r)%4)) -: 8] = s[127-8*(r+4*c) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
    return o;
  endfunction

  // ---------------------------------------------------------------------------------------------
  // Key schedule, one round key at a time
  // ---------------------------------------------------------------------------------------------
  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  // rk_{r-1} -> rk_r
  function automatic logic [127:0] key_fwd(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = sub_rot_word(rk[31:0]) ^ {rc, 24'h000000};
    n0 = rk[127:96] ^ t;
    n1 = rk[95:64] ^ n0;
    n2 = rk[63:32] ^ n1;
    n3 = rk[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // rk_r -> rk_{r-1}; last word is recovered first since w0 depends on it.
  function automatic logic [127:0] key_bwd(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = rk[31:0] ^ rk[63:32];
    w2 = rk[63:32] ^ rk[95:64];
    w1 = rk[95:64] ^ rk[127:96];
    w0 = rk[127:96] ^ sub_rot_word(w3) ^ {rc, 24'h000000};
    return {w0, w1, w2, w3};
  endfunction

  // ---------------------------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------------------------
  logic [1:0]   r_fsm;
  logic [127:0] r_state;
  logic [127:0] r_rk;
  logic [3:0]   r_round;
  logic [127:0] r_out;
  logic         r_done;

  logic [1:0]   w_fsm_d;
  logic [127:0] w_state_d;
  logic [127:0] w_rk_d;
  logic [3:0]   w_round_d;
  logic [127:0] w_out_d;
  logic         w_done_d;

  // ---------------------------------------------------------------------------------------------
  // Round datapaths. r_round is the round number when encrypting and during key expansion;
  // in the inverse rounds it is the index of the round key currently held in r_rk (10 down to 1).
  // ---------------------------------------------------------------------------------------------
  logic [7:0]   w_rcon;
  logic [127:0] w_rk_fwd;
  logic [127:0] w_rk_bwd;
  logic [127:0] w_enc_sr;
  logic [127:0] w_enc_next;
  logic [127:0] w_dec_pre;
  logic [127:0] w_dec_ark;
  logic [127:0] w_dec_next;

  assign w_rcon     = rcon(r_round);
  assign w_rk_fwd   = key_fwd(r_rk, w_rcon);
  assign w_rk_bwd   = key_bwd(r_rk, w_rcon);

  assign w_enc_sr   = shift_rows(sub_bytes(r_state));
  assign w_enc_next = ((r_round == 4'd10) ? w_enc_sr : mix_columns(w_enc_sr)) ^ w_rk_fwd;

  // The first inverse step also strips rk10, which is already in r_rk at that point.
  assign w_dec_pre  = (r_round == 4'd10) ? (r_state ^ r_rk) : r_state;
  assign w_dec_ark  = inv_sub_bytes(inv_shift_rows(w_dec_pre)) ^ w_rk_bwd;
  assign w_dec_next = (r_round == 4'd1) ? w_dec_ark : inv_mix_columns(w_dec_ark);

  // ---------------------------------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    w_fsm_d   = r_fsm;
    w_state_d = r_state;
    w_rk_d    = r_rk;
    w_round_d = r_round;
    w_out_d   = r_out;
    w_done_d  = r_done;
    case (r_fsm)
      StIdle: begin
        if (inputsLoadedFlag) begin
          w_rk_d    = key;
          w_round_d = 4'd1;
          if (DECRYPT != 0) begin
            w_state_d = inputData;
            w_fsm_d   = StKeyExp;
          end else begin
            w_state_d = inputData ^ key;
            w_fsm_d   = StRound;
          end
        end
      end
      StKeyExp: begin
        w_rk_d = w_rk_fwd;
        // Stay on 10 so the inverse rounds start from rk10 with its Rcon.
        if (r_round == 4'd10) w_fsm_d = StRound;
        else w_round_d = r_round + 4'd1;
      end
      StRound: begin
        if (DECRYPT != 0) begin
          w_state_d = w_dec_next;
          w_rk_d    = w_rk_bwd;
          if (r_round == 4'd1) begin
            w_out_d  = w_dec_next;
            w_done_d = 1'b1;
            w_fsm_d  = StDone;
          end else begin
            w_round_d = r_round - 4'd1;
          end
        end else begin
          w_state_d = w_enc_next;
          w_rk_d    = w_rk_fwd;
          if (r_round == 4'd10) begin
            w_out_d  = w_enc_next;
            w_done_d = 1'b1;
            w_fsm_d  = StDone;
          end else begin
            w_round_d = r_round + 4'd1;
          end
        end
      end
      StDone: begin
        // Output is kept; only the flag drops when the request is withdrawn.
        if (!inputsLoadedFlag) begin
          w_fsm_d  = StIdle;
          w_done_d = 1'b0;
        end
      end
      default: w_fsm_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (resetModule) begin
      r_fsm   <= StIdle;
      r_state <= '0;
      r_rk    <= '0;
      r_round <= '0;
      r_out   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_fsm   <= w_fsm_d;
      r_state <= w_state_d;
      r_rk    <= w_rk_d;
      r_round <= w_round_d;
      r_out   <= w_out_d;
      r_done  <= w_done_d;
    end
  end

  assign outputData   = r_out;
  assign dataDoneFlag = r_done;

endmodule

// File: tb/tb_aes128_cipher_core.sv
// tb_aes128_cipher_core
//   Drives one encrypting and one decrypting aes128_cipher_core with the FIPS-197 vectors and
//   random blocks, comparing against a byte-array AES model built from generated S-box tables.
module tb_aes128_cipher_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [127:0] e_in, e_key, e_out;
  logic         e_ld, e_done;
  logic [127:0] d_in, d_key, d_out;
  logic         d_ld, d_done;

  aes128_cipher_core #(.DECRYPT(0)) u_enc (
    .clock            (clk),
    .resetModule      (rst),
    .inputData        (e_in),
    .key              (e_key),
    .inputsLoadedFlag (e_ld),
    .outputData       (e_out),
    .dataDoneFlag     (e_done)
  );

  aes128_cipher_core #(.DECRYPT(1)) u_dec (
    .clock            (clk),
    .resetModule      (rst),
    .inputData        (d_in),
    .key              (d_key),
    .inputsLoadedFlag (d_ld),
    .outputData       (d_out),
    .dataDoneFlag     (d_done)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] sb  [256];
  logic [7:0] isb [256];

  // ------------------------------------------------------------------ reference model
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = xt(a);
    end
    return p;
  endfunction

  // Walk the multiplicative group with generator 3 and its inverse to fill the S-box.
  task automatic build_tables();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
    for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
  endtask

  task automatic ref_aes(input bit dec, input logic [127:0] k, input logic [127:0] blk,
                         output logic [127:0] res);
    logic [31:0] w [44];
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [31:0] wd;
    logic [7:0]  rc, a0, a1, a2, a3;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      wd = w[i-1];
      if (i % 4 == 0) begin
        wd = {sb[wd[23:16]], sb[wd[15:8]], sb[wd[7:0]], sb[wd[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ wd;
    end
    for (int i = 0; i < 16; i++) s[i] = blk[127-8*i -: 8];
    if (!dec) begin
      for (int rnd = 0; rnd <= 10; rnd++) begin
        if (rnd > 0) begin
          for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
          for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) t[r+4*c] = s[r+4*((c+r)%4)];
          s = t;
          if (rnd < 10) begin
            for (int c = 0; c < 4; c++) begin
              a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
              s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
              s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
              s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
              s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
          end
        end
        for (int i = 0; i < 16; i++) begin
          wd = w[4*rnd + i/4];
          s[i] = s[i] ^ wd[31-8*(i%4) -: 8];
        end
      end
    end else begin
      for (int rnd = 10; rnd >= 0; rnd--) begin
        if (rnd < 10) begin
          for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) t[r+4*((c+r)%4)] = s[r+4*c];
          s = t;
          for (int i = 0; i < 16; i++) s[i] = isb[s[i]];
        end
        for (int i = 0; i < 16; i++) begin
          wd = w[4*rnd + i/4];
          s[i] = s[i] ^ wd[31-8*(i%4) -: 8];
        end
        if (rnd < 10 && rnd > 0) begin
          for (int c = 0; c < 4; c++) begin
            a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
            s[4*c]   = gm(a0, 8'h0e) ^ gm(a1, 8'h0b) ^ gm(a2, 8'h0d) ^ gm(a3, 8'h09);
            s[4*c+1] = gm(a0, 8'h09) ^ gm(a1, 8'h0e) ^ gm(a2, 8'h0b) ^ gm(a3, 8'h0d);
            s[4*c+2] = gm(a0, 8'h0d) ^ gm(a1, 8'h09) ^ gm(a2, 8'h0e) ^ gm(a3, 8'h0b);
            s[4*c+3] = gm(a0, 8'h0b) ^ gm(a1, 8'h0d) ^ gm(a2, 8'h09) ^ gm(a3, 8'h0e);
          end
        end
      end
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ------------------------------------------------------------------ stimulus driver
  // Drops the request for one edge, loads on the next, then waits (bounded) for done.
  // lat = clocks from load edge to done (-1 on timeout); changes = cycles where outputData
  // moved before done. drop_at > 0 scrambles inputs and drops the request after that edge.
  task automatic run_op(input bit dec, input logic [127:0] k, input logic [127:0] blk,
                        input int drop_at, output logic [127:0] res, output int lat,
                        output int changes);
    logic [127:0] prev;
    @(negedge clk);
    if (dec) d_ld = 1'b0; else e_ld = 1'b0;
    @(negedge clk);
    if (dec) begin d_key = k; d_in = blk; d_ld = 1'b1; prev = d_out; end
    else begin e_key = k; e_in = blk; e_ld = 1'b1; prev = e_out; end
    @(posedge clk);
    lat = -1;
    changes = 0;
    res = '0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (dec ? d_done : e_done) begin
        lat = n;
        res = dec ? d_out : e_out;
        break;
      end
      if ((dec ? d_out : e_out) !== prev) changes++;
      if (n == drop_at) begin
        if (dec) begin d_key = rand128(); d_in = rand128(); d_ld = 1'b0; end
        else begin e_key = rand128(); e_in = rand128(); e_ld = 1'b0; end
      end
    end
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (e_out !== 128'h0 || e_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_enc got out=%h done=%b want 0/0", e_out, e_done);
    end
    total++;
    if (d_out !== 128'h0 || d_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_dec got out=%h done=%b want 0/0", d_out, d_done);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_vectors();
    logic [127:0] vk [2];
    logic [127:0] vp [2];
    logic [127:0] vc [2];
    logic [127:0] res;
    int lat, ch;
    vk[0] = 128'h000102030405060708090a0b0c0d0e0f;
    vp[0] = 128'h00112233445566778899aabbccddeeff;
    vc[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    vk[1] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    vp[1] = 128'h3243f6a8885a308d313198a2e0370734;
    vc[1] = 128'h3925841d02dc09fbdc118597196a0b32;
    for (int v = 0; v < 2; v++) begin
      run_op(1'b0, vk[v], vp[v], 0, res, lat, ch);
      total++;
      if (res !== vc[v] || lat != 10 || ch != 0) begin
        bad++;
        $display("FAIL vec%0d_enc got=%h lat=%0d chg=%0d want=%h lat=10 chg=0",
                 v, res, lat, ch, vc[v]);
      end
      run_op(1'b1, vk[v], vc[v], 0, res, lat, ch);
      total++;
      if (res !== vp[v] || lat != 20 || ch != 0) begin
        bad++;
        $display("FAIL vec%0d_dec got=%h lat=%0d chg=%0d want=%h lat=20 chg=0",
                 v, res, lat, ch, vp[v]);
      end
    end
  endtask

  task automatic test_hold();
    logic [127:0] res;
    logic [127:0] exp;
    int lat, ch;
    exp = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    run_op(1'b0, 128'h0, 128'h0, 0, res, lat, ch);
    total++;
    if (res !== exp || lat != 10) begin
      bad++;
      $display("FAIL zero_enc got=%h lat=%0d want=%h lat=10", res, lat, exp);
    end
    for (int n = 0; n < 30; n++) begin
      @(posedge clk);
      #1;
      total++;
      if (e_out !== exp || e_done !== 1'b1) begin
        bad++;
        $display("FAIL hold_c%0d got out=%h done=%b want %h/1", n, e_out, e_done, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] k, p, res, exp;
    int lat, ch;
    @(negedge clk);
    e_ld = 1'b0;
    @(negedge clk);
    e_key = rand128();
    e_in  = rand128();
    e_ld  = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (e_out !== 128'h0 || e_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid got out=%h done=%b want 0/0", e_out, e_done);
    end
    @(negedge clk);
    rst  = 1'b0;
    e_ld = 1'b0;
    k = rand128();
    p = rand128();
    ref_aes(1'b0, k, p, exp);
    run_op(1'b0, k, p, 0, res, lat, ch);
    total++;
    if (res !== exp || lat != 10 || ch != 0) begin
      bad++;
      $display("FAIL after_reset got=%h lat=%0d chg=%0d want=%h lat=10", res, lat, ch, exp);
    end
  endtask

  task automatic test_midop_change();
    logic [127:0] k, p, res, exp;
    int lat, ch;
    for (int dec = 0; dec < 2; dec++) begin
      k = rand128();
      p = rand128();
      ref_aes(dec[0], k, p, exp);
      run_op(dec[0], k, p, (dec != 0) ? 7 : 3, res, lat, ch);
      total++;
      if (res !== exp || lat != ((dec != 0) ? 20 : 10)) begin
        bad++;
        $display("FAIL midop_dec%0d got=%h lat=%0d want=%h", dec, res, lat, exp);
      end
      // Request already low, so done lasts a single clock.
      @(posedge clk);
      #1;
      total++;
      if ((dec != 0 ? d_done : e_done) !== 1'b0 || (dec != 0 ? d_out : e_out) !== exp) begin
        bad++;
        $display("FAIL midop_pulse_dec%0d got done=%b out=%h want 0/%h", dec,
                 (dec != 0 ? d_done : e_done), (dec != 0 ? d_out : e_out), exp);
      end
    end
    k = rand128();
    p = rand128();
    ref_aes(1'b0, k, p, exp);
    run_op(1'b0, k, p, 0, res, lat, ch);
    repeat (3) @(posedge clk);
    @(negedge clk);
    e_ld = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (e_done !== 1'b0 || e_out !== exp) begin
      bad++;
      $display("FAIL drop_after_done got done=%b out=%h want 0/%h", e_done, e_out, exp);
    end
  endtask

  task automatic test_random();
    logic [127:0] k, p, c, res, exp;
    int lat, ch;
    for (int n = 0; n < 6; n++) begin
      k = rand128();
      p = rand128();
      ref_aes(1'b0, k, p, c);
      run_op(1'b0, k, p, 0, res, lat, ch);
      total++;
      if (res !== c || lat != 10 || ch != 0) begin
        bad++;
        $display("FAIL rnd%0d_enc got=%h lat=%0d chg=%0d want=%h", n, res, lat, ch, c);
      end
      run_op(1'b1, k, res, 0, res, lat, ch);
      total++;
      if (res !== p || lat != 20 || ch != 0) begin
        bad++;
        $display("FAIL rnd%0d_roundtrip got=%h lat=%0d chg=%0d want=%h", n, res, lat, ch, p);
      end
      p = rand128();
      ref_aes(1'b1, k, p, exp);
      run_op(1'b1, k, p, 0, res, lat, ch);
      total++;
      if (res !== exp || lat != 20) begin
        bad++;
        $display("FAIL rnd%0d_dec got=%h lat=%0d want=%h", n, res, lat, exp);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst   = 1'b1;
    e_ld  = 1'b0;
    d_ld  = 1'b0;
    e_in  = '0;
    e_key = '0;
    d_in  = '0;
    d_key = '0;
    build_tables();
    test_reset();
    test_vectors();
    test_hold();
    test_reset_mid();
    test_midop_change();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
